// File: rtl/bloch_energy_scheduler_if.sv
// Request/operand, compute-unit and response bundle of the Bloch energy scheduler.
// The scheduler uses the slave modport; the master modport is the requester/unit side.
interface bloch_energy_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ*32-1:0] req_t;
  logic [NREQ*32-1:0] req_theta;
  logic [NREQ*32-1:0] req_phi;
  logic [NREQ-1:0]    ack;

  logic               dp_trigger;
  logic [31:0]        dp_x;
  logic [31:0]        dp_t;
  logic [31:0]        dp_theta;
  logic [31:0]        dp_phi;
  logic               dp_valid;
  logic [15:0]        dp_real;
  logic [15:0]        dp_imag;

  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_real;
  logic [15:0]        rsp_imag;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  req, req_x, req_t, req_theta, req_phi, dp_valid, dp_real, dp_imag,
    output ack, dp_trigger, dp_x, dp_t, dp_theta, dp_phi,
    output rsp_valid, rsp_id, rsp_real, rsp_imag, rsp_err, busy
  );

  modport master (
    output req, req_x, req_t, req_theta, req_phi, dp_valid, dp_real, dp_imag,
    input  ack, dp_trigger, dp_x, dp_t, dp_theta, dp_phi,
    input  rsp_valid, rsp_id, rsp_real, rsp_imag, rsp_err, busy
  );
endinterface

// File: rtl/bloch_energy_scheduler.sv
// Round-robin scheduler sharing one Bloch complex-frequency unit among NREQ requesters.
// Define BLOCH_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYC cycles).
module bloch_energy_scheduler #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input logic clk,
  input logic reset_n,
  bloch_energy_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            trig_q, trig_d;
  logic [31:0]     x_q, x_d, t_q, t_d, theta_q, theta_d, phi_q, phi_d;
  logic [IDW-1:0]  rr_q, rr_d, id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     real_q, real_d, imag_q, imag_d;
  logic            busy_q, busy_d;

  logic            any_found, hi_found;
  logic [IDW-1:0]  any_win, hi_win, win;

`ifdef BLOCH_SCHED_TIMEOUT_EN
  logic            err_q, err_d;
  logic [4:0]      cnt_q, cnt_d;
`endif

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    any_found = 1'b0;
    hi_found  = 1'b0;
    any_win   = '0;
    hi_win    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        any_found = 1'b1;
        any_win   = IDW'(i);
        if (IDW'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_win   = IDW'(i);
        end
      end
    end
    win = hi_found ? hi_win : any_win;
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = '0;
    trig_d      = 1'b0;
    rsp_valid_d = 1'b0;
    x_d         = x_q;
    t_d         = t_q;
    theta_d     = theta_q;
    phi_d       = phi_q;
    rr_d        = rr_q;
    id_d        = id_q;
    real_d      = real_q;
    imag_d      = imag_q;
`ifdef BLOCH_SCHED_TIMEOUT_EN
    err_d       = err_q;
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_found) begin
          state_d = ISSUE;
          trig_d  = 1'b1;
          id_d    = win;
          rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
              ack_d[i] = 1'b1;
              x_d      = bus.req_x[32*i +: 32];
              t_d      = bus.req_t[32*i +: 32];
              theta_d  = bus.req_theta[32*i +: 32];
              phi_d    = bus.req_phi[32*i +: 32];
            end
          end
        end
      end
      ISSUE: begin
        // A dp_valid coinciding with the trigger is deliberately not looked at here.
        state_d = WAIT;
`ifdef BLOCH_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.dp_valid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          real_d      = bus.dp_real;
          imag_d      = bus.dp_imag;
`ifdef BLOCH_SCHED_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == 5'(TIMEOUT_CYC - 1)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          real_d      = '0;
          imag_d      = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d       = cnt_q + 5'd1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      trig_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      x_q         <= '0;
      t_q         <= '0;
      theta_q     <= '0;
      phi_q       <= '0;
      rr_q        <= '0;
      id_q        <= '0;
      real_q      <= '0;
      imag_q      <= '0;
      busy_q      <= 1'b0;
`ifdef BLOCH_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      trig_q      <= trig_d;
      rsp_valid_q <= rsp_valid_d;
      x_q         <= x_d;
      t_q         <= t_d;
      theta_q     <= theta_d;
      phi_q       <= phi_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      real_q      <= real_d;
      imag_q      <= imag_d;
      busy_q      <= busy_d;
`ifdef BLOCH_SCHED_TIMEOUT_EN
      err_q       <= err_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.ack        = ack_q;
  assign bus.dp_trigger = trig_q;
  assign bus.dp_x       = x_q;
  assign bus.dp_t       = t_q;
  assign bus.dp_theta   = theta_q;
  assign bus.dp_phi     = phi_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_real   = real_q;
  assign bus.rsp_imag   = imag_q;
  assign bus.busy       = busy_q;

`ifdef BLOCH_SCHED_TIMEOUT_EN
  assign bus.rsp_err = err_q;
`else
  // Without the watchdog the limit has no role.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYC);
  assign bus.rsp_err    = 1'b0;
`endif

endmodule
